// File: rtl/bcd_result_converter_if.sv
// Handshake and result bundle between the ALU-result source, the BCD converter and the digit mux.
interface bcd_result_converter_if #(
  parameter int unsigned IN_WIDTH = 11
);
  logic                start;
  logic [IN_WIDTH-1:0] result_in;
  logic                busy;
  logic                done;
  logic [11:0]         BCD_out;
  logic                negative;
  logic                overflow;

  modport master (
    output start, result_in,
    input  busy, done, BCD_out, negative, overflow
  );

  modport slave (
    input  start, result_in,
    output busy, done, BCD_out, negative, overflow
  );
endinterface

// File: rtl/bcd_result_converter.sv
// Signed binary to 3-digit BCD converter (double dabble, one bit per clock).
// Presented digits, sign and saturation flag only change on the DONE cycle.
module bcd_result_converter #(
  parameter int unsigned IN_WIDTH    = 11,
  parameter int unsigned SHIFT_CNT_W = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  bcd_result_converter_if.slave  bus
);

  localparam int unsigned MAG_W = IN_WIDTH + 1;

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  state_t                 state;
  logic [IN_WIDTH-1:0]    in_reg;
  logic [IN_WIDTH-1:0]    mag;
  logic [11:0]            scratch;
  logic [SHIFT_CNT_W-1:0] cnt;
  logic                   sign;
  logic                   ovf_int;

  logic [MAG_W-1:0]       ext;
  logic [MAG_W-1:0]       abs_v;
  logic                   sat;
  logic [IN_WIDTH-1:0]    mag_load;
  logic [11:0]            adj;

  // Magnitude is formed one bit wider so the most negative input survives negation.
  assign ext      = {in_reg[IN_WIDTH-1], in_reg};
  assign abs_v    = in_reg[IN_WIDTH-1] ? (~ext + MAG_W'(1)) : ext;
  assign sat      = 32'(abs_v) > 32'd999;
  assign mag_load = sat ? IN_WIDTH'(999) : IN_WIDTH'(abs_v);

  // Add-3 correction of every digit that would exceed 9 after the next shift.
  always_comb begin
    adj = scratch;
    for (int i = 0; i < 3; i++) begin
      if (scratch[4*i +: 4] >= 4'd5)
        adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      in_reg       <= '0;
      mag          <= '0;
      scratch      <= '0;
      cnt          <= '0;
      sign         <= 1'b0;
      ovf_int      <= 1'b0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.BCD_out  <= 12'h000;
      bus.negative <= 1'b0;
      bus.overflow <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            in_reg   <= bus.result_in;
            bus.busy <= 1'b1;
            state    <= LOAD;
          end
        end
        LOAD: begin
          sign    <= in_reg[IN_WIDTH-1];
          mag     <= mag_load;
          ovf_int <= sat;
          scratch <= '0;
          cnt     <= SHIFT_CNT_W'(IN_WIDTH);
          state   <= SHIFT;
        end
        SHIFT: begin
          scratch <= {adj[10:0], mag[IN_WIDTH-1]};
          mag     <= {mag[IN_WIDTH-2:0], 1'b0};
          cnt     <= cnt - SHIFT_CNT_W'(1);
          if (cnt == SHIFT_CNT_W'(1)) begin
            bus.busy <= 1'b0;
            state    <= DONE;
          end
        end
        DONE: begin
          bus.BCD_out  <= scratch;
          bus.negative <= sign;
          bus.overflow <= ovf_int;
          bus.done     <= 1'b1;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_result_converter.sv
// Self-checking bench: cycle-level reference model of the converter, checked every cycle,
// plus directed scenarios with literal expectations and randomized sweeps.
module tb_bcd_result_converter;

  localparam int unsigned IN_WIDTH = 11;
  localparam int          PERIOD   = IN_WIDTH + 3;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  bcd_result_converter_if #(.IN_WIDTH(IN_WIDTH)) bus ();

  bcd_result_converter #(.IN_WIDTH(IN_WIDTH), .SHIFT_CNT_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: {negative, overflow, bcd} from plain arithmetic.
  function automatic logic [13:0] ref_conv(input int v);
    int mag;
    logic ovf;
    mag = (v < 0) ? -v : v;
    ovf = mag > 999;
    if (ovf) mag = 999;
    return {v < 0, ovf, 4'(mag / 100), 4'((mag / 10) % 10), 4'(mag % 10)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Timing model: a request is accepted when idle (or on the done cycle) and finishes PERIOD edges later.
  int          rem;
  logic [13:0] pend;
  logic [13:0] held;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem  <= 0;
      pend <= '0;
      held <= '0;
    end else begin
      if (rem <= 1 && bus.start) begin
        rem  <= PERIOD;
        pend <= ref_conv(int'($signed(bus.result_in)));
      end else if (rem > 0) begin
        rem <= rem - 1;
      end
      if (rem == 2) held <= pend;
    end
  end

  always @(negedge clk) begin
    check("busy", 32'(bus.busy), 32'(rem >= 3));
    check("done", 32'(bus.done), 32'(rem == 1));
    check("bcd", 32'(bus.BCD_out), 32'(held[11:0]));
    check("negative", 32'(bus.negative), 32'(held[13]));
    check("overflow", 32'(bus.overflow), 32'(held[12]));
  end

  // One request from idle; checks start-to-done latency.
  task automatic do_conv(input int v);
    int n;
    @(negedge clk);
    bus.start     = 1'b1;
    bus.result_in = IN_WIDTH'(v);
    @(negedge clk);
    bus.start = 1'b0;
    n = 1;
    while (!bus.done && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("latency", 32'(n), 32'(PERIOD));
  endtask

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    rst_n         = 1'b0;
    bus.start     = 1'b0;
    bus.result_in = '0;

    check("model_961", 32'(ref_conv(961)), 32'({2'b00, 12'h961}));
    check("model_m47", 32'(ref_conv(-47)), 32'({2'b10, 12'h047}));
    check("model_1023", 32'(ref_conv(1023)), 32'({2'b01, 12'h999}));
    check("model_m1024", 32'(ref_conv(-1024)), 32'({2'b11, 12'h999}));

    repeat (3) @(negedge clk);
    check("rst_bcd", 32'(bus.BCD_out), 32'h000);
    check("rst_busy", 32'(bus.busy), 32'h0);
    rst_n = 1'b1;

    do_conv(961);
    check("bcd_961", 32'(bus.BCD_out), 32'h961);
    check("neg_961", 32'(bus.negative), 32'h0);
    do_conv(-47);
    check("bcd_m47", 32'(bus.BCD_out), 32'h047);
    check("neg_m47", 32'(bus.negative), 32'h1);
    do_conv(0);
    check("bcd_0", 32'(bus.BCD_out), 32'h000);
    check("neg_0", 32'(bus.negative), 32'h0);
    do_conv(1023);
    check("bcd_1023", 32'(bus.BCD_out), 32'h999);
    check("ovf_1023", 32'(bus.overflow), 32'h1);
    do_conv(-1024);
    check("bcd_m1024", 32'(bus.BCD_out), 32'h999);
    check("neg_m1024", 32'({bus.negative, bus.overflow}), 32'h3);

    // A start while busy is dropped.
    @(negedge clk);
    bus.start = 1'b1; bus.result_in = IN_WIDTH'(123);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    bus.start = 1'b1; bus.result_in = IN_WIDTH'(456);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (25) @(negedge clk);
    check("busy_ignore", 32'(bus.BCD_out), 32'h123);

    // Reset in the 5th shift cycle discards the conversion.
    do_conv(500);
    check("bcd_500", 32'(bus.BCD_out), 32'h500);
    @(negedge clk);
    bus.start = 1'b1; bus.result_in = IN_WIDTH'(7);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_bcd", 32'(bus.BCD_out), 32'h000);
    check("midrst_flags", 32'({bus.busy, bus.done, bus.negative, bus.overflow}), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("midrst_hold", 32'(bus.BCD_out), 32'h000);
    do_conv(7);
    check("bcd_7", 32'(bus.BCD_out), 32'h007);

    // Start held high: restarts every PERIOD cycles.
    @(negedge clk);
    bus.start = 1'b1; bus.result_in = IN_WIDTH'(88);
    repeat (40) @(negedge clk);
    bus.start = 1'b0;
    repeat (20) @(negedge clk);
    check("bcd_88", 32'(bus.BCD_out), 32'h088);

    // Exhaustive sweep in a randomized permutation order.
    begin
      int off;
      off = int'($urandom_range(0, 2047));
      for (int i = 0; i < 2048; i++) begin
        int v;
        v = ((i * 1237 + off) % 2048) - 1024;
        do_conv(v);
      end
    end

    // Random start traffic, including requests while busy.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      bus.start     = ($urandom_range(0, 2) == 0);
      bus.result_in = IN_WIDTH'($urandom);
    end
    @(negedge clk);
    bus.start = 1'b0;
    repeat (20) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bcd_result_converter.md
Name: bcd_result_converter

Overview:
- Sequential signed-binary to 3-digit BCD converter using shift-and-add-3 (double dabble), one bit per clock.
- Sits directly upstream of the seven-segment digit mux. It takes the registered ALU result and produces the 12-bit BCD word and the sign flag that the digit mux consumes.
- Holds its last result stable between conversions so the display never shows partial values.

Parameters:
- IN_WIDTH, 11, width of the two's-complement ALU result input; legal range 4..11.
- SHIFT_CNT_W, 4, width of the internal shift counter; must satisfy 2^SHIFT_CNT_W > IN_WIDTH.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request a conversion of result_in; sampled only in IDLE.
- result_in  input  IN_WIDTH  signed two's-complement ALU result.
- busy  output  1  high while a conversion is in progress (LOAD through SHIFT).
- done  output  1  one-cycle pulse when BCD_out, negative and overflow update.
- BCD_out  output  12  {hundreds, tens, ones} BCD digits of the magnitude.
- negative  output  1  high when the converted result was negative.
- overflow  output  1  high when the magnitude exceeded 999 and was saturated.

Behaviour:
- Reset (async, rst_n low):
  - state = IDLE.
  - BCD_out = 12'h000; negative = 0; overflow = 0; busy = 0; done = 0.
  - Shift counter and working registers are cleared.
  - Takes effect immediately, including mid-conversion; the partial result is discarded and never presented.
- FSM states: IDLE, LOAD, SHIFT, DONE.
- IDLE:
  - busy = 0.
  - If start = 1 on a rising edge, capture result_in into an input register and go to LOAD.
  - Otherwise stay in IDLE.
- LOAD (1 cycle):
  - sign = MSB of the captured value.
  - mag = |value|, computed IN_WIDTH+1 bits wide so that the most negative value (-2^(IN_WIDTH-1)) is handled.
  - If mag > 999: mag = 999, ovf_int = 1; else ovf_int = 0.
  - Clear the 12-bit BCD scratch register and load the counter with IN_WIDTH.
  - Go to SHIFT.
- SHIFT (exactly IN_WIDTH cycles):
  - Each cycle, add 3 to every scratch digit >= 5.
  - Then shift {scratch, mag} left by 1, bringing mag's MSB into scratch bit 0.
  - Decrement the counter. After the cycle in which the counter reaches 0, go to DONE.
- DONE (1 cycle):
  - Register BCD_out = scratch, negative = sign, overflow = ovf_int.
  - done = 1 for this cycle only; busy = 0.
  - Unconditionally go to IDLE.
- Latency: start sampled at edge N → done high during the cycle after edge N+IN_WIDTH+2 (edge N+13 for the default).
- Outputs:
  - BCD_out, negative and overflow change only on the DONE edge and hold otherwise.
  - The digit mux may sample them at any time.
- start handling:
  - start while not in IDLE is ignored; there is no queueing.
  - start held high continuously restarts a conversion every IN_WIDTH+3 cycles.
- Negative zero cannot occur: result_in = 0 gives negative = 0.
- Digits are never > 9 in BCD_out. Saturated values read 12'h999.
- No combinational paths from inputs to outputs.

Test Plan:
- rst_n low, then release; start=1 for 1 cycle with result_in=11'd961 → done pulses exactly 13 cycles after the start edge; BCD_out=12'h961, negative=0, overflow=0; busy high for the 12 preceding cycles.
- result_in=-47 (11'h7D1) → BCD_out=12'h047, negative=1, overflow=0. Then result_in=0 → BCD_out=12'h000, negative=0.
- result_in=11'd1023 → BCD_out=12'h999, overflow=1, negative=0. Then result_in=-1024 (11'h400) → BCD_out=12'h999, overflow=1, negative=1.
- Convert 11'd123; while busy, pulse start with result_in=11'd456 → only one done pulse; BCD_out=12'h123; the second request is not serviced.
- Convert 11'd500 to completion, then start a conversion of 11'd7 and assert rst_n low at the 5th SHIFT cycle:
  - BCD_out, negative and overflow go to 0 immediately; done never pulses.
  - After release, start with 11'd7 → BCD_out=12'h007 after 13 cycles.
- Hold start=1 for 40 cycles with result_in=11'd88 → done pulses every 14 cycles, BCD_out=12'h088 stable between pulses; exhaustive sweep of -1024..1023 against a reference model.
